// File: rtl/rv32_pkg.sv
// Shared RV32 core types: data width, fetch-queue entry layout and fetch FSM encoding.
package rv32_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush, occupancy count and reset-cleared storage.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DEPTH_C);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (do_pop && !do_push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// RV32I fetch stage: issues imem reads for pc, tags them, queues returned words for decode.
// state   | meaning
// ST_IDLE | one dead cycle after reset release, nothing issued
// ST_RUN  | normal fetch; flushes are handled by the drop counter
module ifetch_queue
   import rv32_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int MAX_OUT = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc,
   input  logic            jump_enable,
   output logic            fetch_stall,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(MAX_OUT) + 1;
   localparam logic [CW:0]   DEPTH_W   = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

   fetch_state_e  state_q, state_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] q_count;
   logic [TW-1:0] tag_count;
   logic          q_empty, q_full, tag_empty, tag_full;
   logic          credit_ok, req_acc, rsp_drop, q_push, q_pop;
   logic [XLEN-1:0] tag_pc;
   fetch_entry_t  q_wdata, q_head;

   // Queued words plus words still in flight may never exceed the queue size.
   assign credit_ok = ({1'b0, q_count} + {1'b0, out_cnt_q}) < DEPTH_W;

   always_comb begin
      state_d        = state_q;
      imem_req_valid = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN:  imem_req_valid = !jump_enable && credit_ok && (out_cnt_q < MAX_OUT_C);
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_acc       = imem_req_valid && imem_req_ready;
   assign fetch_stall   = !req_acc;
   assign imem_req_addr = {pc[XLEN-1:2], 2'b00};

   assign rsp_drop    = imem_rsp_valid && (drop_cnt_q != '0);
   assign q_push      = imem_rsp_valid && !rsp_drop && !jump_enable;
   assign instr_valid = !q_empty;
   assign q_pop       = instr_valid && instr_ready && !jump_enable;
   assign q_wdata     = '{pc: tag_pc, instr: imem_rsp_data};
   assign instr       = q_head.instr;
   assign instr_pc    = q_head.pc;

   always_comb begin
      out_cnt_d  = out_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (req_acc && !imem_rsp_valid)      out_cnt_d = out_cnt_q + 1'b1;
      else if (!req_acc && imem_rsp_valid) out_cnt_d = out_cnt_q - 1'b1;
      // Nothing issues in a jump cycle, so every request still in flight afterwards is stale.
      if (jump_enable)   drop_cnt_d = imem_rsp_valid ? out_cnt_q - 1'b1 : out_cnt_q;
      else if (rsp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_q (
      .clk     (clk),
      .rst_n   (reset),
      .flush_i (jump_enable),
      .push_i  (q_push),
      .wdata_i (q_wdata),
      .pop_i   (q_pop),
      .rdata_o (q_head),
      .empty_o (q_empty),
      .full_o  (q_full),
      .count_o (q_count)
   );

   sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_q (
      .clk     (clk),
      .rst_n   (reset),
      .flush_i (1'b0),
      .push_i  (req_acc),
      .wdata_i (pc),
      .pop_i   (imem_rsp_valid),
      .rdata_o (tag_pc),
      .empty_o (tag_empty),
      .full_o  (tag_full),
      .count_o (tag_count)
   );

   assert property (@(posedge clk) disable iff (!reset) !(q_push && q_full && !q_pop));
   assert property (@(posedge clk) disable iff (!reset) imem_rsp_valid |-> !tag_empty);
   assert property (@(posedge clk) disable iff (!reset) req_acc |-> !tag_full);
   assert property (@(posedge clk) disable iff (!reset) out_cnt_q == CW'(tag_count));
   assert property (@(posedge clk) disable iff (!reset) drop_cnt_q <= out_cnt_q);

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: PC stage, in-order memory and decode driven around a queue-level model.
module tb_ifetch_queue;

   localparam int DEPTH   = 2;
   localparam int MAX_OUT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        jump_enable;
   logic        fetch_stall;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc             (pc),
      .jump_enable    (jump_enable),
      .fetch_stall    (fetch_stall),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   typedef struct { logic [31:0] addr; int rdy; bit doomed; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

   mreq_t       mem_q[$];      // requests accepted by memory, not yet answered
   ent_t        oq[$];         // words decode should see, oldest first
   logic [31:0] delivered[$];  // instr_pc values observed at each handshake
   int          errors = 0;
   int          checks = 0;
   int          cyc;
   logic [31:0] pc_m;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          obs_valid, obs_stall;
   logic [31:0] obs_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
   endfunction

   task automatic model_reset();
      mem_q.delete();
      oq.delete();
      pc_m = '0;
      cyc  = 0;
   endtask

   // One clock of PC stage, memory and decode, with the model compared every cycle.
   task automatic step(input bit jmp, input logic [31:0] tgt, input bit rq_rdy,
                       input bit rsp_en, input bit dec_rdy);
      bit    exp_rv, acc, rsp, pop;
      mreq_t r;
      ent_t  e;
      @(negedge clk);
      jump_enable    = jmp;
      pc             = pc_m;
      imem_req_ready = rq_rdy;
      instr_ready    = dec_rdy;
      rsp = rsp_en && (mem_q.size() > 0) && (mem_q[0].rdy <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
      #1;
      exp_rv = (cyc >= 1) && !jmp && (oq.size() + mem_q.size() < DEPTH) && (mem_q.size() < MAX_OUT);
      checks++;
      if (imem_req_valid !== exp_rv) begin
         errors++;
         $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
      end
      checks++;
      if (fetch_stall !== !(exp_rv && rq_rdy)) begin
         errors++;
         $display("FAIL fetch_stall cyc=%0d got=%b exp=%b", cyc, fetch_stall, !(exp_rv && rq_rdy));
      end
      checks++;
      if (imem_req_addr !== {pc_m[31:2], 2'b00}) begin
         errors++;
         $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, pc_m);
      end
      checks++;
      if (instr_valid !== (oq.size() > 0)) begin
         errors++;
         $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, oq.size() > 0);
      end
      if (oq.size() > 0) begin
         checks++;
         if (instr_pc !== oq[0].pc || instr !== oq[0].ins) begin
            errors++;
            $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                     cyc, instr_pc, instr, oq[0].pc, oq[0].ins);
         end
      end
      obs_valid = instr_valid;
      obs_stall = fetch_stall;
      obs_addr  = imem_req_addr;
      acc = exp_rv && rq_rdy;
      pop = (oq.size() > 0) && dec_rdy && !jmp;
      if (pop) delivered.push_back(instr_pc);
      @(posedge clk);
      if (pop) void'(oq.pop_front());
      if (rsp) begin
         r = mem_q.pop_front();
         if (!r.doomed && !jmp) begin
            e.pc  = r.addr;
            e.ins = mem_word(r.addr);
            oq.push_back(e);
         end
      end
      if (acc) begin
         r.addr   = pc_m;
         r.rdy    = cyc + int'($urandom_range(lat_max, lat_min));
         r.doomed = 1'b0;
         mem_q.push_back(r);
      end
      if (jmp) begin
         oq.delete();
         foreach (mem_q[i]) mem_q[i].doomed = 1'b1;
         pc_m = tgt;
      end else if (acc) begin
         pc_m = pc_m + 32'd4;
      end
      cyc++;
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || fetch_stall !== 1'b1 ||
          instr !== 32'h0 || instr_pc !== 32'h0) begin
         errors++;
         $display("FAIL %s got valid=%b req=%b stall=%b instr=%h pc=%h exp 0 0 1 0 0",
                  tag, instr_valid, imem_req_valid, fetch_stall, instr, instr_pc);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; pc = '0; jump_enable = 0; imem_req_ready = 0;
      imem_rsp_valid = 0; imem_rsp_data = '0; instr_ready = 0;
      #1;
      check_reset_outputs("reset_t0");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_held");
      @(posedge clk);
      #2 reset = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      int first = -1;
      lat_min = 1; lat_max = 1;
      delivered.delete();
      for (int i = 0; i < 10; i++) begin
         int c = cyc;
         step(0, '0, 1, 1, 1);
         if (obs_valid && first < 0) first = c;
      end
      checks++;
      if (first != 3) begin
         errors++;
         $display("FAIL first_valid_cycle got=%0d exp=3", first);
      end
      checks++;
      if (delivered.size() < 3 || delivered[0] !== 32'h0 || delivered[1] !== 32'h4 || delivered[2] !== 32'h8) begin
         errors++;
         $display("FAIL basic_order got n=%0d first=%h exp 0,4,8", delivered.size(),
                  delivered.size() > 0 ? delivered[0] : 32'hx);
      end
   endtask

   task automatic check_contiguous(input string tag);
      for (int i = 1; i < delivered.size(); i++) begin
         checks++;
         if (delivered[i] !== delivered[i-1] + 32'd4) begin
            errors++;
            $display("FAIL %s idx=%0d got=%h exp=%h", tag, i, delivered[i], delivered[i-1] + 32'd4);
         end
      end
   endtask

   task automatic test_decode_stall();
      delivered.delete();
      for (int i = 0; i < 6; i++) step(0, '0, 1, 1, 0);
      checks++;
      if (obs_stall !== 1'b1 || obs_valid !== 1'b1) begin
         errors++;
         $display("FAIL decode_stall_hold got stall=%b valid=%b exp 1 1", obs_stall, obs_valid);
      end
      for (int i = 0; i < 12; i++) step(0, '0, 1, 1, 1);
      checks++;
      if (delivered.size() < 4) begin
         errors++;
         $display("FAIL decode_stall_drain got=%0d words exp>=4", delivered.size());
      end
      check_contiguous("decode_stall_seq");
   endtask

   task automatic test_mem_stall();
      logic [31:0] held;
      delivered.delete();
      step(0, '0, 0, 1, 1);
      held = obs_addr;
      for (int i = 0; i < 3; i++) begin
         step(0, '0, 0, 1, 1);
         checks++;
         if (obs_stall !== 1'b1 || obs_addr !== held) begin
            errors++;
            $display("FAIL mem_stall got stall=%b addr=%h exp 1 %h", obs_stall, obs_addr, held);
         end
      end
      for (int i = 0; i < 10; i++) step(0, '0, 1, 1, 1);
      check_contiguous("mem_stall_seq");
   endtask

   task automatic test_jump_outstanding();
      bit found = 0;
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mem_q.size() == 2) found = 1;
         else step(0, '0, 1, 1, 1);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL jump_setup got outstanding=%0d exp=2", mem_q.size());
      end
      step(1, 32'h100, 1, 1, 1);
      delivered.delete();
      step(0, '0, 1, 1, 1);
      checks++;
      if (obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL jump_valid_after got=%b exp=0", obs_valid);
      end
      for (int i = 0; i < 15; i++) step(0, '0, 1, 1, 1);
      checks++;
      if (delivered.size() == 0 || delivered[0] !== 32'h100) begin
         errors++;
         $display("FAIL jump_first_pc got=%h exp=00000100", delivered.size() > 0 ? delivered[0] : 32'hx);
      end
      check_contiguous("jump_seq");
   endtask

   task automatic test_jump_with_rsp();
      bit found = 0;
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 20 && !found; i++) begin
         if (oq.size() > 0 && mem_q.size() > 0 && mem_q[0].rdy <= cyc) found = 1;
         else step(0, '0, 1, 1, 1);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL jump_rsp_setup got queued=%0d inflight=%0d exp both>0", oq.size(), mem_q.size());
      end
      step(1, 32'h200, 1, 1, 1);
      checks++;
      if (obs_valid !== 1'b1) begin
         errors++;
         $display("FAIL jump_rsp_valid_in got=%b exp=1", obs_valid);
      end
      delivered.delete();
      step(0, '0, 1, 1, 1);
      checks++;
      if (obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL jump_rsp_valid_after got=%b exp=0", obs_valid);
      end
      for (int i = 0; i < 12; i++) step(0, '0, 1, 1, 1);
      checks++;
      if (delivered.size() == 0 || delivered[0] !== 32'h200) begin
         errors++;
         $display("FAIL jump_rsp_first_pc got=%h exp=00000200", delivered.size() > 0 ? delivered[0] : 32'hx);
      end
   endtask

   task automatic test_reset_mid();
      lat_min = 2; lat_max = 2;
      for (int i = 0; i < 5; i++) step(0, '0, 1, 1, 1);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check_reset_outputs("reset_mid");
      jump_enable = 0; imem_rsp_valid = 0; imem_req_ready = 0; instr_ready = 0;
      @(posedge clk);
      #2 reset = 1'b1;
      model_reset();
      lat_min = 1; lat_max = 1;
      delivered.delete();
      for (int i = 0; i < 8; i++) step(0, '0, 1, 1, 1);
      checks++;
      if (delivered.size() == 0 || delivered[0] !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_restart got=%h exp=00000000", delivered.size() > 0 ? delivered[0] : 32'hx);
      end
   endtask

   task automatic test_random();
      logic [31:0] t;
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 400; i++) begin
         t = $urandom;
         step(($urandom % 20) == 0, t & 32'h0000_FFFC, ($urandom % 4) != 0,
              ($urandom % 3) != 0, ($urandom % 3) != 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_decode_stall();
      test_mem_stall();
      test_jump_outstanding();
      test_jump_with_rsp();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
